// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared types, key map and defaults for the 4x4 keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int c_SCAN_DIV_DEFAULT  = 50000;
    localparam int c_DEB_SCANS_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Entry {row_idx, col_idx} occupies bits [4*entry +: 4].
    localparam logic [63:0] c_KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        int entry;
        entry = int'({row_idx, col_idx});
        return c_KEY_MAP[4*entry +: 4];
    endfunction

    // Lowest-index active-low column wins when several are pressed together.
    function automatic logic [1:0] lowest_low(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_if
// Brief    : Keypad matrix pins and decoded key outputs of the scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;

    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_out;
    logic       pressed;
    logic       key_valid;

    // master: keypad hardware / register side, slave: the scanner itself
    modport master (
        output col,
        input  row,
        input  key_out,
        input  pressed,
        input  key_valid
    );

    modport slave (
        input  col,
        output row,
        output key_out,
        output pressed,
        output key_valid
    );

endinterface
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
// Module   : keypad_sync
// Brief    : Two-stage synchronizer, resets to all-ones (idle pulled-up bus).
// Revision : 1.0 - initial release
// ============================================================================
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  wire               clk,
    input  wire               rst,
    input  wire  [WIDTH-1:0]  i_d,
    output logic [WIDTH-1:0]  o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner with tick-based press/release debounce.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = c_SCAN_DIV_DEFAULT,
    parameter int DEB_SCANS = c_DEB_SCANS_DEFAULT
) (
    input wire               clk,
    input wire               rst,
    keypad_scanner_if.slave  kp
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CNT_W = $clog2(DEB_SCANS + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DEB_MAX  = c_CNT_W'(DEB_SCANS);

    logic [3:0]          w_col_sync;
    logic                w_tick;
    logic                w_col_low;
    logic [c_CNT_W-1:0]  w_cnt_inc;

    logic [c_DIV_W-1:0]  r_div;
    state_t              r_state,    w_state;
    logic [1:0]          r_row_idx,  w_row_idx;
    logic [1:0]          r_col_idx,  w_col_idx;
    logic [c_CNT_W-1:0]  r_cnt,      w_cnt;
    logic [3:0]          r_key,      w_key;
    logic                r_pressed,  w_pressed;
    logic                r_valid,    w_valid;

    keypad_sync #(
        .WIDTH (4)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (kp.col),
        .o_q (w_col_sync)
    );

    // Free-running scan divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick    = (r_div == c_DIV_LAST);
    assign w_col_low = ~w_col_sync[r_col_idx];
    assign w_cnt_inc = (r_cnt == c_DEB_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_SCAN;
            r_row_idx <= 2'd0;
            r_col_idx <= 2'd0;
            r_cnt     <= '0;
            r_key     <= 4'h0;
            r_pressed <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_row_idx <= w_row_idx;
            r_col_idx <= w_col_idx;
            r_cnt     <= w_cnt;
            r_key     <= w_key;
            r_pressed <= w_pressed;
            r_valid   <= w_valid;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_row_idx = r_row_idx;
        w_col_idx = r_col_idx;
        w_cnt     = r_cnt;
        w_key     = r_key;
        w_pressed = r_pressed;
        w_valid   = 1'b0;

        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_col_sync == 4'b1111) begin
                        w_row_idx = r_row_idx + 2'd1;
                    end else begin
                        w_col_idx = lowest_low(w_col_sync);
                        w_cnt     = '0;
                        w_state   = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_col_low) begin
                        w_cnt = w_cnt_inc;
                        if (w_cnt_inc == c_DEB_MAX) begin
                            w_state   = ST_HELD;
                            w_key     = key_lookup(r_row_idx, r_col_idx);
                            w_pressed = 1'b1;
                            w_valid   = 1'b1;
                        end
                    end else begin
                        // Bounce: resume rotation from the frozen row
                        w_cnt   = '0;
                        w_state = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (!w_col_low) begin
                        w_cnt   = '0;
                        w_state = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_col_low) begin
                        w_cnt = w_cnt_inc;
                        if (w_cnt_inc == c_DEB_MAX) begin
                            w_cnt     = '0;
                            w_pressed = 1'b0;
                            w_state   = ST_SCAN;
                        end
                    end else begin
                        w_cnt   = '0;
                        w_state = ST_HELD;
                    end
                end
                default: begin
                    w_state = ST_SCAN;
                end
            endcase
        end
    end

    assign kp.row       = ~(4'b0001 << r_row_idx);
    assign kp.key_out   = r_key;
    assign kp.pressed   = r_pressed;
    assign kp.key_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Keypad-matrix model with scoreboard of expected accepted key codes.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.slave)
    );

    always #5 clk = ~clk;

    // Physical matrix: keys[r*4+c] closed connects row r to column c
    logic [15:0] keys = 16'h0;
    logic [3:0]  col_drv;

    always_comb begin
        col_drv = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kif.row[r] && keys[r*4+c]) col_drv[c] = 1'b0;
            end
        end
    end
    assign kif.col = col_drv;

    logic [3:0] ref_map [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] exp_q [$];
    logic [3:0] last_key = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every key_valid must match the oldest outstanding expectation
    always @(negedge clk) begin
        logic       has_exp;
        logic [3:0] e;
        check("row_one_cold", $countones(~kif.row), 1);
        if (kif.key_valid) begin
            has_exp = (exp_q.size() != 0);
            check("key_valid_expected", {31'd0, has_exp}, 1);
            if (has_exp) begin
                e = exp_q.pop_front();
                check("key_out_at_valid", kif.key_out, e);
                check("pressed_at_valid", kif.pressed, 1);
            end
        end
    end

    task automatic wait_pressed(input logic lvl, input int budget, input string name);
        int n = 0;
        while (kif.pressed !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, kif.pressed, lvl);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic clean_press(input int r, input int c);
        exp_q.push_back(ref_map[r][c]);
        keys[r*4+c] = 1'b1;
        wait_pressed(1'b1, 40, "press_accept");
        repeat ($urandom_range(0, 20)) @(negedge clk);
        keys = 16'h0;
        wait_pressed(1'b0, 24, "release_accept");
        last_key = ref_map[r][c];
        check("key_out_after_release", kif.key_out, last_key);
        wait_drain(4);
    endtask

    task automatic bounce_press(input int r, input int c);
        keys[r*4+c] = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        keys = 16'h0;
        repeat (24) @(negedge clk);
        check("bounce_not_pressed", kif.pressed, 0);
        check("bounce_key_out_kept", kif.key_out, last_key);
    endtask

    task automatic dual_press(input int r, input int c1, input int c2);
        exp_q.push_back(ref_map[r][c1]);
        keys[r*4+c1] = 1'b1;
        keys[r*4+c2] = 1'b1;
        wait_pressed(1'b1, 40, "dual_accept");
        check("dual_lowest_col", kif.key_out, ref_map[r][c1]);
        keys[$urandom_range(0, 15)] = 1'b1;
        repeat (20) @(negedge clk);
        check("dual_still_pressed", kif.pressed, 1);
        keys = 16'h0;
        wait_pressed(1'b0, 24, "dual_release");
        last_key = ref_map[r][c1];
        wait_drain(4);
    endtask

    task automatic glitch_press(input int r, input int c);
        exp_q.push_back(ref_map[r][c]);
        keys[r*4+c] = 1'b1;
        wait_pressed(1'b1, 40, "glitch_accept");
        repeat (6) @(negedge clk);
        keys = 16'h0;
        repeat (7) @(negedge clk);
        check("pressed_through_glitch", kif.pressed, 1);
        keys[r*4+c] = 1'b1;
        repeat (12) @(negedge clk);
        check("pressed_after_glitch", kif.pressed, 1);
        keys = 16'h0;
        wait_pressed(1'b0, 24, "glitch_release");
        last_key = ref_map[r][c];
        wait_drain(4);
    endtask

    task automatic reset_mid_held(input int r, input int c);
        exp_q.push_back(ref_map[r][c]);
        keys[r*4+c] = 1'b1;
        wait_pressed(1'b1, 40, "pre_reset_accept");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_row", kif.row, 4'b1110);
        check("rst_key_out", kif.key_out, 0);
        check("rst_pressed", kif.pressed, 0);
        check("rst_key_valid", kif.key_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(ref_map[r][c]);
        wait_pressed(1'b1, 40, "reaccept_after_reset");
        keys = 16'h0;
        wait_pressed(1'b0, 24, "post_reset_release");
        last_key = ref_map[r][c];
        wait_drain(4);
    endtask

    initial begin
        logic [3:0] prev;
        int         since;
        int         nchg;
        int         r, c1, c2;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_row", kif.row, 4'b1110);
        check("reset_key_out", kif.key_out, 0);
        check("reset_pressed", kif.pressed, 0);
        check("reset_key_valid", kif.key_valid, 0);
        rst = 1'b1;

        // Idle rotation
        prev  = kif.row;
        since = 0;
        nchg  = 0;
        repeat (64) begin
            @(negedge clk);
            since++;
            if (kif.row !== prev) begin
                check("idle_rotate", kif.row, {prev[2:0], prev[3]});
                if (nchg > 0) check("idle_period", since, SCAN_DIV);
                nchg++;
                since = 0;
                prev  = kif.row;
            end
        end
        check("idle_change_count", {31'd0, nchg >= 15}, 1);
        check("idle_pressed", kif.pressed, 0);

        clean_press(1, 2);
        bounce_press(3, 0);
        dual_press(0, 0, 1);
        glitch_press(2, 1);
        reset_mid_held(1, 3);

        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: clean_press(r, $urandom_range(0, 3));
                1: bounce_press(r, $urandom_range(0, 3));
                2: begin
                    c1 = $urandom_range(0, 2);
                    c2 = $urandom_range(c1 + 1, 3);
                    dual_press(r, c1, c2);
                end
                default: glitch_press(r, $urandom_range(0, 3));
            endcase
        end

        repeat (8) @(negedge clk);
        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
